// File: rtl/axi_lite_simplebus_bridge.sv
// AXI-Lite target bridged onto a single-outstanding Simplebus register master.
// Writes and reads share one FSM; contention for the bus alternates between them.
module axi_lite_simplebus_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] axi_in_awaddr,
  input  logic [2:0]            axi_in_awprot,
  input  logic                  axi_in_awvalid,
  output logic                  axi_in_awready,
  input  logic [31:0]           axi_in_wdata,
  input  logic [3:0]            axi_in_wstrb,
  input  logic                  axi_in_wvalid,
  output logic                  axi_in_wready,
  output logic                  axi_in_bvalid,
  output logic [1:0]            axi_in_bresp,
  input  logic                  axi_in_bready,
  input  logic [ADDR_WIDTH-1:0] axi_in_araddr,
  input  logic [2:0]            axi_in_arprot,
  input  logic                  axi_in_arvalid,
  output logic                  axi_in_arready,
  output logic                  axi_in_rvalid,
  output logic [1:0]            axi_in_rresp,
  output logic [31:0]           axi_in_rdata,
  input  logic                  axi_in_rready,
  output logic [31:0]           sb_address,
  output logic [31:0]           sb_write_data,
  output logic                  sb_write_strobe,
  output logic                  sb_read_strobe,
  input  logic                  sb_ready,
  input  logic                  sb_read_valid,
  input  logic [31:0]           sb_read_data
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_ISSUE = 3'd1;
  localparam logic [2:0] WR_WAIT  = 3'd2;
  localparam logic [2:0] WR_RESP  = 3'd3;
  localparam logic [2:0] RD_ISSUE = 3'd4;
  localparam logic [2:0] RD_WAIT  = 3'd5;
  localparam logic [2:0] RD_RESP  = 3'd6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]            state_q, state_d;
  logic                  prefer_wr_q, prefer_wr_d;
  logic                  awready_q, awready_d;
  logic                  arready_q, arready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic wr_req, grant_wr, grant_rd, wr_bad, rd_bad, timed_out;
  logic unused_prot;

  assign unused_prot = ^{axi_in_awprot, axi_in_arprot};

  assign wr_req    = axi_in_awvalid && axi_in_wvalid;
  assign grant_wr  = wr_req && (prefer_wr_q || !axi_in_arvalid);
  assign grant_rd  = axi_in_arvalid && !grant_wr;
  assign wr_bad    = (axi_in_wstrb != 4'hF) || (axi_in_awaddr[1:0] != 2'b00);
  assign rd_bad    = (axi_in_araddr[1:0] != 2'b00);
  // The last busy cycle is the one where the counter sits at TIMEOUT_CYCLES-1.
  assign timed_out = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d     = state_q;
    prefer_wr_d = prefer_wr_q;
    awready_d   = 1'b0;
    arready_d   = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bresp_d     = bresp_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (awready_q) begin
          if (wr_req) begin
            addr_d      = axi_in_awaddr;
            wdata_d     = axi_in_wdata;
            prefer_wr_d = 1'b0;
            cnt_d       = '0;
            if (wr_bad) begin
              bresp_d = RESP_SLVERR;
              state_d = WR_RESP;
            end else begin
              bresp_d = RESP_OKAY;
              state_d = WR_ISSUE;
            end
          end
        end else if (arready_q) begin
          if (axi_in_arvalid) begin
            addr_d      = axi_in_araddr;
            prefer_wr_d = 1'b1;
            cnt_d       = '0;
            rdata_d     = '0;
            if (rd_bad) begin
              rresp_d = RESP_SLVERR;
              state_d = RD_RESP;
            end else begin
              rresp_d = RESP_OKAY;
              state_d = RD_ISSUE;
            end
          end
        end else begin
          awready_d = grant_wr;
          arready_d = grant_rd;
        end
      end
      WR_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sb_ready) begin
          state_d = WR_WAIT;
        end else if (timed_out) begin
          bresp_d = RESP_SLVERR;
          state_d = WR_RESP;
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Completion outranks a timeout landing in the same cycle.
        if (sb_ready) begin
          bresp_d = RESP_OKAY;
          state_d = WR_RESP;
        end else if (timed_out) begin
          bresp_d = RESP_SLVERR;
          state_d = WR_RESP;
        end
      end
      RD_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sb_ready) begin
          state_d = RD_WAIT;
        end else if (timed_out) begin
          rresp_d = RESP_SLVERR;
          rdata_d = '0;
          state_d = RD_RESP;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sb_read_valid) begin
          rdata_d = sb_read_data;
          rresp_d = RESP_OKAY;
          state_d = RD_RESP;
        end else if (timed_out) begin
          rresp_d = RESP_SLVERR;
          rdata_d = '0;
          state_d = RD_RESP;
        end
      end
      WR_RESP: if (axi_in_bready) state_d = IDLE;
      RD_RESP: if (axi_in_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      prefer_wr_q <= 1'b1;
      awready_q   <= 1'b0;
      arready_q   <= 1'b0;
      addr_q      <= '0;
      bresp_q     <= 2'b00;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      prefer_wr_q <= prefer_wr_d;
      awready_q   <= awready_d;
      arready_q   <= arready_d;
      addr_q      <= addr_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // Write data is only visible while strobing, so it needs no reset.
  always_ff @(posedge clock) begin
    wdata_q <= wdata_d;
  end

  assign axi_in_awready  = awready_q;
  assign axi_in_wready   = awready_q;
  assign axi_in_arready  = arready_q;
  assign axi_in_bvalid   = (state_q == WR_RESP);
  assign axi_in_rvalid   = (state_q == RD_RESP);
  assign axi_in_bresp    = bresp_q;
  assign axi_in_rresp    = rresp_q;
  assign axi_in_rdata    = rdata_q;
  assign sb_address      = 32'(addr_q);
  assign sb_write_strobe = (state_q == WR_ISSUE) && sb_ready;
  assign sb_read_strobe  = (state_q == RD_ISSUE) && sb_ready;
  assign sb_write_data   = sb_write_strobe ? wdata_q : 32'h0;

endmodule

// File: tb/tb_axi_lite_simplebus_bridge.sv
// Directed bench for axi_lite_simplebus_bridge: AXI-Lite master tasks plus a
// Simplebus slave model whose read latency is set per test.
module tb_axi_lite_simplebus_bridge;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] axi_in_awaddr, axi_in_wdata, axi_in_araddr, axi_in_rdata;
  logic [2:0]  axi_in_awprot, axi_in_arprot;
  logic [3:0]  axi_in_wstrb;
  logic        axi_in_awvalid, axi_in_awready, axi_in_wvalid, axi_in_wready;
  logic        axi_in_bvalid, axi_in_bready, axi_in_arvalid, axi_in_arready;
  logic        axi_in_rvalid, axi_in_rready;
  logic [1:0]  axi_in_bresp, axi_in_rresp;
  logic [31:0] sb_address, sb_write_data, sb_read_data;
  logic        sb_write_strobe, sb_read_strobe, sb_ready, sb_read_valid;

  axi_lite_simplebus_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .axi_in_awaddr(axi_in_awaddr), .axi_in_awprot(axi_in_awprot),
    .axi_in_awvalid(axi_in_awvalid), .axi_in_awready(axi_in_awready),
    .axi_in_wdata(axi_in_wdata), .axi_in_wstrb(axi_in_wstrb),
    .axi_in_wvalid(axi_in_wvalid), .axi_in_wready(axi_in_wready),
    .axi_in_bvalid(axi_in_bvalid), .axi_in_bresp(axi_in_bresp), .axi_in_bready(axi_in_bready),
    .axi_in_araddr(axi_in_araddr), .axi_in_arprot(axi_in_arprot),
    .axi_in_arvalid(axi_in_arvalid), .axi_in_arready(axi_in_arready),
    .axi_in_rvalid(axi_in_rvalid), .axi_in_rresp(axi_in_rresp),
    .axi_in_rdata(axi_in_rdata), .axi_in_rready(axi_in_rready),
    .sb_address(sb_address), .sb_write_data(sb_write_data),
    .sb_write_strobe(sb_write_strobe), .sb_read_strobe(sb_read_strobe),
    .sb_ready(sb_ready), .sb_read_valid(sb_read_valid), .sb_read_data(sb_read_data)
  );

  initial forever #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Simplebus slave model and protocol monitor, sampled 1ns after the falling edge.
  int wr_strobes = 0, rd_strobes = 0, wr_strobe_cyc = 0, rd_strobe_cyc = 0, rvld_cyc = 0;
  int both_strobe = 0, both_valid = 0, wdata_leak = 0;
  int rd_delay = 4;
  int cd = 0;
  logic [31:0] rd_resp_data = 32'h0;
  logic [31:0] last_wr_addr = 32'h0, last_wr_data = 32'h0, last_rd_addr = 32'h0;

  initial begin
    sb_read_valid = 1'b0;
    sb_read_data  = 32'hFFFF_FFFF;
    forever begin
      @(negedge clock);
      #1;
      if (sb_write_strobe) begin
        wr_strobes++;
        wr_strobe_cyc = cyc;
        last_wr_addr  = sb_address;
        last_wr_data  = sb_write_data;
      end
      if (sb_read_strobe) begin
        rd_strobes++;
        rd_strobe_cyc = cyc;
        last_rd_addr  = sb_address;
      end
      if (sb_write_strobe && sb_read_strobe) both_strobe++;
      if (axi_in_bvalid && axi_in_rvalid) both_valid++;
      if (!sb_write_strobe && sb_write_data != 32'h0) wdata_leak++;
      sb_read_valid = 1'b0;
      sb_read_data  = 32'hFFFF_FFFF;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          sb_read_valid = 1'b1;
          sb_read_data  = rd_resp_data;
          rvld_cyc      = cyc;
        end
      end
      if (sb_read_strobe && rd_delay > 0) cd = rd_delay;
    end
  end

  int hs_w, hs_r, bv_c, rv_c, rhold_seen, rstable_err;
  logic [1:0]  bresp_o, rresp_o;
  logic [31:0] rdata_o;
  logic        rv_after;
  int order[$];

  // Issues an optional write and an optional read together and runs both to completion.
  task automatic run_txn(input bit do_w, input bit do_r, input logic [31:0] waddr,
                         input logic [31:0] wdat, input logic [3:0] wstrb,
                         input logic [31:0] raddr, input int rhold);
    bit w_pend, r_pend, b_need, r_need, w_drop, ar_drop, rr_drop;
    int n;
    @(negedge clock);
    axi_in_awaddr = waddr; axi_in_wdata = wdat; axi_in_wstrb = wstrb; axi_in_araddr = raddr;
    axi_in_awvalid = do_w; axi_in_wvalid = do_w; axi_in_arvalid = do_r;
    axi_in_bready = 1'b1; axi_in_rready = 1'b0;
    w_pend = do_w; b_need = do_w; r_pend = do_r; r_need = do_r;
    w_drop = 0; ar_drop = 0; rr_drop = 0;
    rhold_seen = 0; rstable_err = 0; rv_after = 1'b0; n = 0;
    while ((w_pend || r_pend || b_need || r_need || w_drop || ar_drop || rr_drop) && n < 200) begin
      @(negedge clock);
      n++;
      if (w_drop) begin axi_in_awvalid = 1'b0; axi_in_wvalid = 1'b0; w_drop = 0; end
      if (ar_drop) begin axi_in_arvalid = 1'b0; ar_drop = 0; end
      if (rr_drop) begin axi_in_rready = 1'b0; rr_drop = 0; rv_after = axi_in_rvalid; end
      if (w_pend && axi_in_awready && axi_in_wready) begin
        hs_w = cyc; order.push_back(1); w_pend = 0; w_drop = 1;
      end
      if (r_pend && axi_in_arready) begin
        hs_r = cyc; order.push_back(2); r_pend = 0; ar_drop = 1;
      end
      if (b_need && axi_in_bvalid) begin
        bv_c = cyc; bresp_o = axi_in_bresp; b_need = 0;
      end
      if (r_need && axi_in_rvalid) begin
        if (rhold_seen == 0) begin
          rv_c = cyc; rresp_o = axi_in_rresp; rdata_o = axi_in_rdata;
        end else if (axi_in_rdata !== rdata_o || axi_in_rresp !== rresp_o) begin
          rstable_err++;
        end
        if (rhold_seen == rhold) begin
          axi_in_rready = 1'b1; r_need = 0; rr_drop = 1;
        end else begin
          rhold_seen++;
        end
      end
    end
    if (n >= 200) chk("txn_done", 32'd0, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 32'({axi_in_awready, axi_in_wready, axi_in_arready, axi_in_bvalid,
                            axi_in_rvalid, sb_write_strobe, sb_read_strobe}), 32'h0);
    chk({tag, "_resp"}, 32'({axi_in_bresp, axi_in_rresp}), 32'h0);
    chk({tag, "_rdata"}, axi_in_rdata, 32'h0);
    chk({tag, "_sbaddr"}, sb_address, 32'h0);
    chk({tag, "_sbwdata"}, sb_write_data, 32'h0);
  endtask

  function automatic logic [31:0] order_code();
    logic [31:0] c = 32'h0;
    for (int i = 0; i < order.size(); i++) c = (c << 4) | 32'(order[i]);
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

  int ws0, rs0, cnt;

  initial begin
    reset = 1'b1; sb_ready = 1'b1;
    axi_in_awaddr = 0; axi_in_wdata = 0; axi_in_wstrb = 0; axi_in_araddr = 0;
    axi_in_awprot = 3'b111; axi_in_arprot = 3'b101;
    axi_in_awvalid = 0; axi_in_wvalid = 0; axi_in_arvalid = 0;
    axi_in_bready = 0; axi_in_rready = 0;
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;

    // AW or W alone must never be accepted.
    @(negedge clock);
    axi_in_awaddr = 32'h40; axi_in_awvalid = 1'b1;
    cnt = 0;
    repeat (5) begin @(negedge clock); if (axi_in_awready || axi_in_wready) cnt++; end
    chk("aw_alone", 32'(cnt), 32'd0);
    axi_in_awvalid = 1'b0; axi_in_wvalid = 1'b1;
    cnt = 0;
    repeat (5) begin @(negedge clock); if (axi_in_awready || axi_in_wready) cnt++; end
    chk("w_alone", 32'(cnt), 32'd0);
    axi_in_wvalid = 1'b0;

    // Plain write: strobe the cycle after accept, BVALID three cycles after.
    ws0 = wr_strobes;
    run_txn(1, 0, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    chk("wr_strobes", 32'(wr_strobes - ws0), 32'd1);
    chk("wr_sb_addr", last_wr_addr, 32'h40);
    chk("wr_sb_data", last_wr_data, 32'hDEADBEEF);
    chk("wr_strobe_lat", 32'(wr_strobe_cyc - hs_w), 32'd1);
    chk("wr_bvalid_lat", 32'(bv_c - hs_w), 32'd3);
    chk("wr_bresp", 32'(bresp_o), 32'd0);

    // Read with 4-cycle slave latency and RREADY held low while RVALID waits 3 cycles.
    rs0 = rd_strobes; rd_delay = 4; rd_resp_data = 32'h12345678;
    run_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h44, 3);
    chk("rd_strobes", 32'(rd_strobes - rs0), 32'd1);
    chk("rd_sb_addr", last_rd_addr, 32'h44);
    chk("rd_data", rdata_o, 32'h12345678);
    chk("rd_rresp", 32'(rresp_o), 32'd0);
    chk("rd_rvalid_lat", 32'(rv_c - rvld_cyc), 32'd1);
    chk("rd_hold_cycles", 32'(rhold_seen), 32'd3);
    chk("rd_hold_stable", 32'(rstable_err), 32'd0);
    chk("rd_rvalid_clear", 32'(rv_after), 32'd0);

    // Simultaneous write+read, twice: write, read, write, read.
    order.delete(); rd_delay = 1;
    rd_resp_data = 32'hCAFE0001;
    run_txn(1, 1, 32'h60, 32'h11112222, 4'hF, 32'h64, 0);
    rd_resp_data = 32'hCAFE0002;
    run_txn(1, 1, 32'h68, 32'h33334444, 4'hF, 32'h6C, 0);
    chk("contend_order", order_code(), 32'h1212);
    chk("contend_wdata", last_wr_data, 32'h33334444);
    chk("contend_rdata", rdata_o, 32'hCAFE0002);

    // After a lone write, the read side wins the next contention.
    order.delete(); rd_resp_data = 32'hCAFE0003;
    run_txn(1, 0, 32'h70, 32'h55556666, 4'hF, 32'h0, 0);
    run_txn(1, 1, 32'h74, 32'h77778888, 4'hF, 32'h78, 0);
    chk("alt_order", order_code(), 32'h121);

    // Silent slave: timeout after 16 busy cycles, SLVERR and zero data.
    rs0 = rd_strobes; rd_delay = 0;
    run_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h80, 0);
    chk("to_rd_strobes", 32'(rd_strobes - rs0), 32'd1);
    chk("to_rd_lat", 32'(rv_c - hs_r), 32'd17);
    chk("to_rd_rresp", 32'(rresp_o), 32'd2);
    chk("to_rd_rdata", rdata_o, 32'h0);
    rd_delay = 2; rd_resp_data = 32'h5A5A1234;
    run_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h84, 0);
    chk("post_to_rresp", 32'(rresp_o), 32'd0);
    chk("post_to_rdata", rdata_o, 32'h5A5A1234);

    // Completion in the last counted cycle beats the timeout.
    rd_delay = 15; rd_resp_data = 32'h0F0F1111;
    run_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h88, 0);
    chk("edge_rresp", 32'(rresp_o), 32'd0);
    chk("edge_rdata", rdata_o, 32'h0F0F1111);

    // Write while the bus never becomes ready times out in WR_ISSUE with no strobe.
    ws0 = wr_strobes; sb_ready = 1'b0;
    run_txn(1, 0, 32'h90, 32'h99990000, 4'hF, 32'h0, 0);
    sb_ready = 1'b1;
    chk("to_wr_strobes", 32'(wr_strobes - ws0), 32'd0);
    chk("to_wr_lat", 32'(bv_c - hs_w), 32'd17);
    chk("to_wr_bresp", 32'(bresp_o), 32'd2);

    // Partial strobe, misaligned write and misaligned read bypass the bus.
    ws0 = wr_strobes; rs0 = rd_strobes;
    run_txn(1, 0, 32'hA0, 32'h12121212, 4'h3, 32'h0, 0);
    chk("bad_strb_bresp", 32'(bresp_o), 32'd2);
    run_txn(1, 0, 32'hA1, 32'h34343434, 4'hF, 32'h0, 0);
    chk("bad_waddr_bresp", 32'(bresp_o), 32'd2);
    run_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h42, 0);
    chk("bad_raddr_rresp", 32'(rresp_o), 32'd2);
    chk("bad_raddr_rdata", rdata_o, 32'h0);
    chk("bad_no_wstrobe", 32'(wr_strobes - ws0), 32'd0);
    chk("bad_no_rstrobe", 32'(rd_strobes - rs0), 32'd0);

    // Reset pulsed while the write waits for completion.
    ws0 = wr_strobes;
    @(negedge clock);
    axi_in_awaddr = 32'h50; axi_in_wdata = 32'hA5A50001; axi_in_wstrb = 4'hF;
    axi_in_awvalid = 1'b1; axi_in_wvalid = 1'b1; axi_in_bready = 1'b1;
    cnt = 0;
    while (!axi_in_awready && cnt < 20) begin @(negedge clock); cnt++; end
    if (cnt >= 20) chk("rstw_accept", 32'd0, 32'd1);
    @(negedge clock);
    axi_in_awvalid = 1'b0; axi_in_wvalid = 1'b0;
    @(negedge clock);
    sb_ready = 1'b0; reset = 1'b1;
    @(negedge clock);
    check_zero("rstw");
    reset = 1'b0; sb_ready = 1'b1;
    cnt = 0;
    repeat (6) begin @(negedge clock); if (axi_in_bvalid) cnt++; end
    chk("rstw_no_bvalid", 32'(cnt), 32'd0);
    chk("rstw_strobes", 32'(wr_strobes - ws0), 32'd1);
    order.delete(); rd_delay = 1; rd_resp_data = 32'hBEEF0042;
    run_txn(1, 1, 32'hB0, 32'h0F0F0F0F, 4'hF, 32'hB4, 0);
    chk("rstw_order", order_code(), 32'h12);
    chk("rstw_bresp", 32'(bresp_o), 32'd0);
    chk("rstw_wdata", last_wr_data, 32'h0F0F0F0F);
    chk("rstw_rdata", rdata_o, 32'hBEEF0042);

    repeat (2) @(negedge clock);
    chk("both_strobes", 32'(both_strobe), 32'd0);
    chk("both_valids", 32'(both_valid), 32'd0);
    chk("wdata_leak", 32'(wdata_leak), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_simplebus_bridge.md
AXI_LITE_SIMPLEBUS_BRIDGE -- requirements
Module: axi_lite_simplebus_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, 32, width of the AXI-Lite address forwarded onto sb_address (zero-extended to 32 bits).
REQ-002 Parameter TIMEOUT_CYCLES, 255, maximum number of cycles to wait for a Simplebus completion before an error response.
REQ-003 Port clock  input  1  single clock for all logic.
REQ-004 Port reset  input  1  reset; synchronous and active-high.
REQ-005 Port axi_in  axi_lite.slave  DATA_WIDTH=32, ADDR_WIDTH  upstream AXI-Lite target (AW/W/B/AR/R channels).
REQ-006 Port sb  Simplebus.master  32-bit address and data  downstream register bus: sb_address, sb_write_data, sb_write_strobe, sb_read_strobe out; sb_ready, sb_read_valid, sb_read_data in.

Function
REQ-007 FSM states SHALL be IDLE, WR_ISSUE, WR_WAIT, WR_RESP, RD_ISSUE, RD_WAIT and RD_RESP; one transaction is in flight at a time.
REQ-008 In IDLE, AWREADY and WREADY SHALL assert together for exactly one cycle only when AWVALID and WVALID are both high; AW or W alone is never accepted.
REQ-009 In IDLE, ARREADY SHALL assert for one cycle when ARVALID is high and no write is granted that cycle.
REQ-010 When a write (AW+W) and a read (AR) are both pending in IDLE, the grant SHALL alternate: the request type not granted last wins; after reset the write wins first.
REQ-011 On write accept, AWADDR, WDATA and WSTRB SHALL be latched; if WSTRB != 4'hF or AWADDR[1:0] != 0, the FSM SHALL skip Simplebus and go to WR_RESP with BRESP=2'b10.
REQ-012 On read accept, ARADDR SHALL be latched; if ARADDR[1:0] != 0, the FSM SHALL skip Simplebus and go to RD_RESP with RRESP=2'b10 and RDATA=0.
REQ-013 WR_ISSUE: when sb_ready=1, drive sb_address and sb_write_data with latched values and assert sb_write_strobe for exactly one cycle, then go to WR_WAIT; if sb_ready=0, wait without strobing.
REQ-014 WR_WAIT: the first cycle with sb_ready=1 SHALL complete the write (BRESP=2'b00) and enter WR_RESP.
REQ-015 RD_ISSUE: when sb_ready=1, drive sb_address and assert sb_read_strobe for exactly one cycle, then go to RD_WAIT.
REQ-016 RD_WAIT: on sb_read_valid=1, capture sb_read_data into RDATA with RRESP=2'b00 and enter RD_RESP; sb_read_valid in any other state SHALL be ignored.
REQ-017 WR_RESP/RD_RESP SHALL hold BVALID/RVALID together with BRESP/RRESP/RDATA stable until BREADY/RREADY is high, then return to IDLE on the next cycle.
REQ-018 Minimum latency with sb_ready always high: strobe one cycle after accept; BVALID three cycles after the AW/W handshake; RVALID one cycle after sb_read_valid.
REQ-019 An 8-bit-or-wider timeout counter SHALL clear on entering WR_ISSUE/RD_ISSUE and increment every cycle in WR_ISSUE, WR_WAIT, RD_ISSUE and RD_WAIT; on reaching TIMEOUT_CYCLES it SHALL force the response state with RESP=2'b10 (RDATA=0 for reads).
REQ-020 A completion and the timeout in the same cycle SHALL resolve as a completion (OKAY).
REQ-021 sb_write_strobe and sb_read_strobe SHALL never be high simultaneously; sb_write_data SHALL return to 0 the cycle after the strobe.
REQ-022 AWPROT and ARPROT SHALL be ignored; BVALID and RVALID SHALL never be high simultaneously.

Reset
REQ-023 With reset high at a clock edge, every output SHALL be 0 (all READY/VALID, BRESP, RRESP, RDATA, sb_address, sb_write_data, both strobes) and the FSM SHALL be IDLE.
REQ-024 Reset mid-transaction SHALL abandon it without any response or further strobe; the alternation pointer SHALL reset to write-first.

Verification
REQ-025 Write 0xDEADBEEF to 0x40, sb_ready always 1, BREADY=1 -> one strobe with sb_address=0x40, BVALID three cycles after handshake, BRESP=0.
REQ-026 Read 0x44, slave returns sb_read_valid with 0x12345678 four cycles after the strobe, RREADY low for 3 cycles -> RDATA=0x12345678, RRESP=0, RVALID held for 3 cycles then cleared.
REQ-027 AW+W and AR asserted in the same cycle twice in a row -> write, read, write, read grant order; no overlapping strobes.
REQ-028 Read with the slave never asserting sb_read_valid, TIMEOUT_CYCLES=16 -> RVALID after 16 cycles, RRESP=2'b10, RDATA=0; the next transaction completes normally.
REQ-029 Write with WSTRB=4'h3 and a read to 0x42 -> no Simplebus strobe; BRESP=2'b10, RRESP=2'b10.
REQ-030 Reset pulsed during WR_WAIT -> all outputs 0 next cycle, no BVALID, and a subsequent write succeeds.
